// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-code parser producing make/break events into a FWFT FIFO,
// with a 512-bit key-state vector and watched lane-key press/release pulses.
module ps2_key_event_queue #(
    parameter int unsigned         FIFO_DEPTH    = 8,
    parameter int unsigned         NUM_CH        = 4,
    parameter logic [NUM_CH*9-1:0] WATCH_CODES   = {9'h023, 9'h02B, 9'h03B, 9'h042},
    parameter bit                  REPORT_REPEAT = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    scan_byte,
    input  logic                          scan_valid,
    output logic [511:0]                  key_down,
    output logic [9:0]                    ev_data,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count,
    output logic                          ev_overflow,
    input  logic                          ovf_clr,
    output logic [NUM_CH-1:0]             ch_down,
    output logic [NUM_CH-1:0]             ch_press,
    output logic [NUM_CH-1:0]             ch_release,
    output logic                          parse_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_SKIP} state_t;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ev_t;

    state_t              state_q, state_d;
    logic [2:0]          skip_q, skip_d;
    logic [511:0]        key_down_q, key_down_d;
    logic                parse_err_q, parse_err_d;
    logic [NUM_CH-1:0]   ch_down_q, ch_down_d;
    logic [NUM_CH-1:0]   ch_press_q, ch_press_d;
    logic [NUM_CH-1:0]   ch_release_q, ch_release_d;

    ev_t                 mem_q [FIFO_DEPTH];
    ev_t                 mem_d [FIFO_DEPTH];
    logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]       count_q, count_d;
    ev_t                 ev_data_q, ev_data_d;
    logic                ev_valid_q, ev_valid_d;
    logic                ovf_q, ovf_d;

    logic                is_err, complete, c_brk, c_ext, was_down, new_make;
    logic                push_req, push_ok, pop, full, ovf_set;
    logic [8:0]          idx;
    ev_t                 ev_in;

    // Byte parser, key-state update and lane pulses
    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        key_down_d  = key_down_q;
        parse_err_d = 1'b0;
        complete    = 1'b0;
        c_brk       = 1'b0;
        c_ext       = 1'b0;
        is_err      = (scan_byte == 8'h00) || (scan_byte == 8'hFF);
        if (scan_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (scan_byte == 8'hAA)      key_down_d = '0;
                    else if (scan_byte == 8'hE0) state_d = S_EXT;
                    else if (scan_byte == 8'hF0) state_d = S_BRK;
                    else if (scan_byte == 8'hE1) begin
                        state_d = S_SKIP;
                        skip_d  = 3'd7;
                    end
                    else if (is_err)             parse_err_d = 1'b1;
                    else                         complete = 1'b1;
                end
                S_EXT: begin
                    if (scan_byte == 8'hF0)      state_d = S_EXT_BRK;
                    else if (scan_byte == 8'hE0) state_d = S_EXT;
                    else if (is_err) begin
                        parse_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        complete = 1'b1;
                        c_ext    = 1'b1;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    if (is_err) begin
                        parse_err_d = 1'b1;
                        state_d     = S_IDLE;
                    end else if (scan_byte == 8'hE0 || scan_byte == 8'hF0) begin
                        state_d = S_IDLE;
                    end else begin
                        complete = 1'b1;
                        c_brk    = 1'b1;
                        c_ext    = (state_q == S_EXT_BRK);
                    end
                end
                S_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        idx      = {c_ext, scan_byte};
        was_down = key_down_q[idx];
        if (complete) begin
            key_down_d[idx] = ~c_brk;
            state_d         = S_IDLE;
        end
        new_make = complete && !c_brk && !was_down;
        push_req = complete && (c_brk || !was_down || REPORT_REPEAT);
        ev_in    = '{brk: c_brk, ext: c_ext, code: scan_byte};

        for (int i = 0; i < int'(NUM_CH); i++) begin
            ch_press_d[i]   = new_make && (WATCH_CODES[9*i +: 9] == idx);
            ch_release_d[i] = complete && c_brk && was_down && (WATCH_CODES[9*i +: 9] == idx);
            ch_down_d[i]    = key_down_d[WATCH_CODES[9*i +: 9]];
        end
    end

    // First-word-fall-through event FIFO; head register tracks the post-update read slot
    always_comb begin
        mem_d    = mem_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        count_d  = count_q;
        pop      = ev_valid_q && ev_ready;
        full     = (count_q == CW'(FIFO_DEPTH));
        push_ok  = push_req && (!full || pop);
        ovf_set  = push_req && full && !pop;
        if (push_ok) begin
            mem_d[wr_q] = ev_in;
            wr_d        = wr_q + AW'(1);
        end
        if (pop) rd_d = rd_q + AW'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ev_valid_d = (count_d != '0);
        ev_data_d  = ev_valid_d ? mem_d[rd_d] : '0;
        ovf_d      = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            skip_q       <= '0;
            key_down_q   <= '0;
            parse_err_q  <= 1'b0;
            ch_down_q    <= '0;
            ch_press_q   <= '0;
            ch_release_q <= '0;
            mem_q        <= '{default: '0};
            wr_q         <= '0;
            rd_q         <= '0;
            count_q      <= '0;
            ev_data_q    <= '0;
            ev_valid_q   <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            skip_q       <= skip_d;
            key_down_q   <= key_down_d;
            parse_err_q  <= parse_err_d;
            ch_down_q    <= ch_down_d;
            ch_press_q   <= ch_press_d;
            ch_release_q <= ch_release_d;
            mem_q        <= mem_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            count_q      <= count_d;
            ev_data_q    <= ev_data_d;
            ev_valid_q   <= ev_valid_d;
            ovf_q        <= ovf_d;
        end
    end

    assign key_down    = key_down_q;
    assign ev_data     = ev_data_q;
    assign ev_valid    = ev_valid_q;
    assign ev_count    = count_q;
    assign ev_overflow = ovf_q;
    assign ch_down     = ch_down_q;
    assign ch_press    = ch_press_q;
    assign ch_release  = ch_release_q;
    assign parse_err   = parse_err_q;

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Directed bench: a depth-4 non-repeating queue and a depth-8 repeating queue share one byte stream.
module tb_ps2_key_event_queue;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   scan_byte;
    logic         scan_valid;
    logic         ev_ready;
    logic         ovf_clr;

    logic [511:0] key_down,  rr_key_down;
    logic [9:0]   ev_data,   rr_ev_data;
    logic         ev_valid,  rr_ev_valid;
    logic [2:0]   ev_count;
    logic [3:0]   rr_ev_count;
    logic         ev_overflow, rr_ev_overflow;
    logic [3:0]   ch_down,  ch_press,  ch_release;
    logic [3:0]   rr_ch_down, rr_ch_press, rr_ch_release;
    logic         parse_err, rr_parse_err;

    int n_checks = 0;
    int n_errors = 0;
    int press3   = 0;
    int rel3     = 0;

    always #5 clk = ~clk;

    // ch0/ch2 share 0x01C, ch1 = 0x175, ch3 = 0x023
    ps2_key_event_queue #(
        .FIFO_DEPTH(4), .NUM_CH(4),
        .WATCH_CODES({9'h023, 9'h01C, 9'h175, 9'h01C}),
        .REPORT_REPEAT(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .scan_byte(scan_byte), .scan_valid(scan_valid),
        .key_down(key_down), .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_count(ev_count), .ev_overflow(ev_overflow), .ovf_clr(ovf_clr),
        .ch_down(ch_down), .ch_press(ch_press), .ch_release(ch_release), .parse_err(parse_err)
    );

    ps2_key_event_queue #(
        .FIFO_DEPTH(8), .NUM_CH(4),
        .WATCH_CODES({9'h023, 9'h02B, 9'h03B, 9'h042}),
        .REPORT_REPEAT(1'b1)
    ) dut_rr (
        .clk(clk), .rst(rst), .scan_byte(scan_byte), .scan_valid(scan_valid),
        .key_down(rr_key_down), .ev_data(rr_ev_data), .ev_valid(rr_ev_valid), .ev_ready(ev_ready),
        .ev_count(rr_ev_count), .ev_overflow(rr_ev_overflow), .ovf_clr(ovf_clr),
        .ch_down(rr_ch_down), .ch_press(rr_ch_press), .ch_release(rr_ch_release), .parse_err(rr_parse_err)
    );

    always @(posedge clk) begin
        if (ch_press[3])   press3 <= press3 + 1;
        if (ch_release[3]) rel3   <= rel3 + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the capturing edge
    task automatic send(input logic [7:0] b);
        scan_byte  = b;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [9:0] exp);
        check({tag, "_valid"}, 32'(ev_valid), 32'd1);
        check({tag, "_data"},  32'(ev_data),  32'(exp));
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    int p0, r0;

    initial begin
        rst = 1'b1; scan_byte = 8'h00; scan_valid = 1'b0; ev_ready = 1'b0; ovf_clr = 1'b0;
        idle(3);
        rst = 1'b0;

        check("rst_valid",    32'(ev_valid),    32'd0);
        check("rst_count",    32'(ev_count),    32'd0);
        check("rst_data",     32'(ev_data),     32'd0);
        check("rst_keydown",  32'(|key_down),   32'd0);
        check("rst_ovf",      32'(ev_overflow), 32'd0);
        check("rst_perr",     32'(parse_err),   32'd0);

        // make / break with two channels sharing 0x01C
        send(8'h1C);
        check("mk_key",     32'(key_down[9'h01C]), 32'd1);
        check("mk_press",   32'(ch_press),   32'b0101);
        check("mk_chdown",  32'(ch_down),    32'b0101);
        check("mk_head",    32'(ev_data),    32'h01C);
        send(8'hF0); send(8'h1C);
        check("bk_key",     32'(key_down[9'h01C]), 32'd0);
        check("bk_release", 32'(ch_release), 32'b0101);
        check("bk_count",   32'(ev_count),   32'd2);
        pop_check("mb0", 10'h01C);
        pop_check("mb1", 10'h21C);
        check("mb_empty",   32'(ev_valid),   32'd0);

        // extended key
        send(8'hE0); send(8'h75);
        check("ext_key",   32'(key_down[9'h175]), 32'd1);
        check("ext_press", 32'(ch_press), 32'b0010);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("extb_key",  32'(key_down[9'h175]), 32'd0);
        pop_check("ex0", 10'h175);
        pop_check("ex1", 10'h375);

        // typematic repeat
        p0 = press3; r0 = rel3;
        send(8'h23); send(8'h23); send(8'h23); send(8'h23);
        send(8'hF0); send(8'h23);
        idle(2);
        check("typ_count",   32'(ev_count),    32'd2);
        check("typ_rrcount", 32'(rr_ev_count), 32'd5);
        check("typ_press",   32'(press3 - p0), 32'd1);
        check("typ_release", 32'(rel3 - r0),   32'd1);
        pop_check("ty0", 10'h023);
        pop_check("ty1", 10'h223);
        ev_ready = 1'b1; idle(4); ev_ready = 1'b0;
        check("typ_rrdrain", 32'(rr_ev_count), 32'd0);
        check("typ_popempty", 32'(ev_count),   32'd0);

        // overflow with depth 4
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C); send(8'h35);
        check("ovf_count", 32'(ev_count),    32'd4);
        check("ovf_flag",  32'(ev_overflow), 32'd1);
        check("ovf_head",  32'(ev_data),     32'h015);
        ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
        check("ovf_clr",   32'(ev_overflow), 32'd0);
        ev_ready = 1'b1; send(8'h3C); ev_ready = 1'b0;
        check("pp_count",  32'(ev_count),    32'd4);
        check("pp_ovf",    32'(ev_overflow), 32'd0);
        check("pp_head",   32'(ev_data),     32'h01D);
        ovf_clr = 1'b1; send(8'h43); ovf_clr = 1'b0;
        check("ovf_setwins", 32'(ev_overflow), 32'd1);
        ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
        pop_check("of0", 10'h01D);
        pop_check("of1", 10'h024);
        pop_check("of2", 10'h02D);
        pop_check("of3", 10'h03C);
        check("of_empty", 32'(ev_valid), 32'd0);
        ev_ready = 1'b1; idle(8); ev_ready = 1'b0;

        // Pause sequence is skipped entirely
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        check("pause_count", 32'(ev_count),         32'd0);
        check("pause_k14",   32'(key_down[9'h014]), 32'd0);
        check("pause_k77",   32'(key_down[9'h077]), 32'd0);
        check("pause_held",  32'(key_down[9'h015]), 32'd1);
        send(8'h16);
        pop_check("after_pause", 10'h016);
        send(8'hFF);
        check("perr_pulse", 32'(parse_err), 32'd1);
        @(negedge clk);
        check("perr_end",   32'(parse_err), 32'd0);
        send(8'hAA);
        check("aa_clear",   32'(|key_down), 32'd0);
        check("aa_count",   32'(ev_count),  32'd0);

        // reset aborts an E0 F0 prefix
        send(8'hE0); send(8'hF0);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        send(8'h75);
        pop_check("rst_mid", 10'h075);
        check("rst_mid_key", 32'(key_down[9'h075]), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_queue.md
# ps2_key_event_queue

Parametrised successor to the team's PS/2 keyboard decoder. Parses the raw scan-code byte stream from the PS/2 controller into make/break events and maintains a 512-bit key-state vector. Adds a configurable first-word-fall-through event FIFO, typematic-repeat filtering, Pause-sequence skipping, and NUM_CH watched "lane" keys with press/release pulses for the rhythm-game input path. Sits between the PS/2 controller and the game/scoring logic.

## Interface
- FIFO_DEPTH, 8, event FIFO entries; power of two, ≥2
- NUM_CH, 4, number of watched lane keys, 1..16
- WATCH_CODES, {9'h023, 9'h02B, 9'h03B, 9'h042}, packed NUM_CH×9 {ext,code}; channel i = bits [9i+8:9i]
- REPORT_REPEAT, 0, 1 = re-queue make codes for keys already down

Ports:
- clk  in  1  system clock; sole clock domain
- rst  in  1  reset; synchronous, active-high
- scan_byte  in  8  received PS/2 byte
- scan_valid  in  1  one-cycle strobe, scan_byte valid
- key_down  out  512  bit {ext,code} = 1 while key held
- ev_data  out  10  FIFO head {brk, ext, code}
- ev_valid  out  1  FIFO non-empty
- ev_ready  in  1  pop head when ev_valid && ev_ready
- ev_count  out  $clog2(FIFO_DEPTH)+1  entries held
- ev_overflow  out  1  sticky: an event was dropped
- ovf_clr  in  1  clears ev_overflow
- ch_down  out  NUM_CH  key_down of watched code i
- ch_press  out  NUM_CH  one-cycle pulse on new make of channel i
- ch_release  out  NUM_CH  one-cycle pulse on break of channel i while down
- parse_err  out  1  one-cycle pulse on 8'h00/8'hFF byte

## Operation
- Parser states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 then F0), SKIP. Transitions only on scan_valid.
- IDLE: AA → clear key_down, stay IDLE, no event. E0 → EXT. F0 → BRK. E1 → SKIP with skip counter = 7. 00/FF → parse_err, stay IDLE. Other byte → complete code {brk=0, ext=0}.
- EXT: F0 → EXT_BRK; E0 → stay EXT; 00/FF → parse_err, IDLE; other → complete {0,1}.
- BRK: 00/FF → parse_err, IDLE; E0/F0 → IDLE, byte discarded; other → complete {1,0}.
- EXT_BRK: 00/FF → parse_err, IDLE; E0/F0 → IDLE, byte discarded; other → complete {1,1}.
- SKIP: decrement the counter per byte; on the byte that brings it to 0 → IDLE. No events are produced and key_down is untouched. AA is not special here.
- Completed code, idx = {ext, code}:
  - Make with key_down[idx]=0: set the bit, push an event, pulse ch_press for matching channels.
  - Make with key_down[idx]=1: push only if REPORT_REPEAT=1; never pulse ch_press.
  - Break: clear the bit and always push. Pulse ch_release only if the bit was set.
  - Return to IDLE.
- FIFO:
  - Push when full and no pop in the same cycle → event dropped, ev_overflow set.
  - Push and pop when full → both succeed, count unchanged, no overflow.
  - Pop when empty → ignored.
  - ovf_clr and a concurrent overflow → ev_overflow stays 1 (set wins).
- Multiple channels may share a code; all matching channels pulse together.

## Timing
- Reset (synchronous): state IDLE, skip counter 0, key_down 0, FIFO empty, ev_valid 0, ev_count 0, ev_data 0, ev_overflow 0, ch_* 0, parse_err 0.
- Reset mid-sequence aborts any prefix or skip in progress; the next byte is parsed from IDLE.
- scan_valid at edge t → key_down, ch_down, ev_valid/ev_data/ev_count update at t+1. ch_press/ch_release/parse_err are high for exactly cycle t+1.
- FWFT: ev_data is valid whenever ev_valid=1. A pop at edge t shows the next head (or ev_valid=0) at t+1.
- Throughput: one byte per cycle; back-to-back scan_valid is legal.
- Pointers wrap modulo FIFO_DEPTH; ev_count ranges 0..FIFO_DEPTH.

## Test plan
- Make/break: bytes 1C, F0, 1C → key_down[0x01C] goes 1 then 0. FIFO holds 0x01C, 0x21C. With WATCH_CODES containing 0x01C: one ch_press pulse, then one ch_release pulse.
- Extended key: E0, 75, E0, F0, 75 → key_down[0x175] toggles 1→0. Events 0x175, 0x375.
- Typematic: 23 ×4, then F0 23, REPORT_REPEAT=0 → two events and a single ch_press. Same stimulus with REPORT_REPEAT=1 → five events.
- Overflow, FIFO_DEPTH=4, ev_ready=0: six makes of distinct keys → ev_count=4 and ev_overflow=1, with the first four codes retained in order. Then ovf_clr → ev_overflow=0. Pop+push when full → count stays 4.
- Pause/errors: E1 14 77 E1 F0 14 F0 77 → no events, key_down unchanged. Then FF → parse_err pulse. Then AA with keys held → key_down=0.
- Reset mid-sequence: E0 F0, then rst, then 75 → make 0x075 queued (not 0x375).
